// File: rtl/fpu_op_sequencer.sv
// Command front end for the fpu datapath: queues (A, B, opcode) commands in a small FIFO,
// issues one at a time, waits for the fpu to settle, then presents the sampled result.
module fpu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [1:0]  cmd_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_opcode,
    input  logic [31:0] fpu_outp,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [1:0]  res_op,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_LAT = CW'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [65:0]   mem_q [DEPTH];
    logic [AW:0]   wptr_q, rptr_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
    logic [1:0]    fpu_op_q, fpu_op_d;
    logic          res_valid_q, res_valid_d;
    logic [31:0]   res_data_q, res_data_d;
    logic [1:0]    res_op_q, res_op_d;

    logic        full, empty, push, pop;
    logic [65:0] head;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign push  = cmd_valid && !full;
    assign head  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_op_d    = fpu_op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    fpu_a_d  = head[65:34];
                    fpu_b_d  = head[33:2];
                    fpu_op_d = head[1:0];
                    cnt_d    = CNT_LAT;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                // Last settling cycle: fpu_outp is valid at this edge.
                if (cnt_q == CNT_ONE) begin
                    res_data_d  = fpu_outp;
                    res_op_d    = fpu_op_q;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_op_q    <= fpu_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: resetting the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= {cmd_a, cmd_b, cmd_op};
    end

    assign cmd_ready  = !full;
    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign fpu_opcode = fpu_op_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_op     = res_op_q;
    assign busy       = (state_q != S_IDLE) || !empty;

endmodule

// File: doc/fpu_op_sequencer.md
# fpu_op_sequencer

Command-side front end for the `fpu` datapath. It accepts floating-point operations (A, B, opcode) through a valid/ready handshake into a small FIFO and issues them to the `fpu` one at a time. It holds the `fpu` operands stable for a fixed settling latency, samples `outp`, and presents the result through a valid/ready handshake. The block sits directly upstream of `fpu` (driving `A`, `B`, `opcode`) and captures its `outp`.

## Interface
- `DEPTH`, 4 — command FIFO entries; power of two, ≥2.
- `LATENCY`, 2 — clk cycles `fpu` operands must be stable before `outp` is sampled; ≥1.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `cmd_valid`  in  1  — command present.
- `cmd_ready`  out  1  — FIFO can accept; equals `!full`.
- `cmd_a`, `cmd_b`  in  32  — IEEE-754 single operands.
- `cmd_op`  in  2  — opcode, passed to `fpu` unmodified.
- `fpu_a`, `fpu_b`  out  32  — registered, to `fpu.A`/`fpu.B`.
- `fpu_opcode`  out  2  — registered, to `fpu.opcode`.
- `fpu_outp`  in  32  — from `fpu.outp`.
- `res_valid`  out  1  — result held.
- `res_ready`  in  1  — consumer accepts.
- `res_data`  out  32  — captured `fpu_outp`.
- `res_op`  out  2  — opcode of the captured result.
- `busy`  out  1  — `state != IDLE || !empty`.

## Operation
- Push on `cmd_valid && cmd_ready`: write {a, b, op} at the write pointer and advance it.
- Pointers are log2(DEPTH)+1 bits. Wrap-around is by natural overflow.
  - full: MSBs differ and low bits are equal.
  - empty: pointers are equal.
- The FIFO has no bypass. A push into an empty FIFO is visible to the FSM the next cycle.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: if `!empty`, pop the head, load `fpu_a/fpu_b/fpu_opcode` from it, set `cnt = LATENCY`, and go to WAIT. Otherwise stay in IDLE.
  - WAIT: `cnt` decrements every cycle. On the edge where `cnt == 1`, load `res_data <= fpu_outp` and `res_op <= fpu_opcode`, set `res_valid <= 1`, and go to HOLD.
  - HOLD: `res_valid`, `res_data` and `res_op` stay stable until `res_ready`. On `res_valid && res_ready`, clear `res_valid` and go to IDLE.
- Only one operation is outstanding at a time. `fpu_*` outputs are never changed outside IDLE→WAIT.
- After an operation, `fpu_*` keep their last values; they are not cleared.
- A push and a pop in the same cycle are both performed; the occupancy count is unchanged.
- When full, `cmd_ready` = 0. A pop that cycle raises `cmd_ready` the next cycle. Commands offered while full are not stored, and the sender must hold them.
- `res_ready` is ignored outside HOLD.

## Timing
- Reset values:
  - `cmd_ready` = 1, `res_valid` = 0, `busy` = 0.
  - `res_data` = 0, `res_op` = 0.
  - `fpu_a` = `fpu_b` = 0, `fpu_opcode` = 0.
  - FIFO empty, FSM in IDLE, `cnt` = 0.
- Latency, with the command accepted at edge t into an empty, idle block:
  - The pop and `fpu_*` load happen at edge t+1.
  - The result is captured at edge t+1+LATENCY.
  - `res_valid` is high from edge t+1+LATENCY, i.e. LATENCY+1 cycles after acceptance.
- If `res_ready` is high on the first HOLD cycle, HOLD lasts 1 cycle. IDLE pops the next command the following cycle.
- Throughput with `res_ready` tied high: one result per LATENCY+2 cycles.
- `fpu_outp` is sampled only at the end of the LATENCY-th stable cycle. Values earlier in WAIT are don't-care.
- Reset mid-operation (`rst` high at any edge):
  - All state and outputs return to reset values at that edge.
  - FIFO contents and the in-flight operation are discarded.
  - No `res_valid` pulse is produced for them.
- `rst` has priority over simultaneous push, pop or result handshake.

## Test plan
- Bench `fpu` stub: drives 32'hFFFF_FFFF until its inputs have been stable for LATENCY cycles, then drives `A ^ B ^ {30'b0, opcode}`.
- Single op, LATENCY=2: push a=32'h4000_0000, b=32'h4040_0000, op=2'b11 at edge t, `res_ready` held 1.
  - Required: `res_valid` rises at edge t+3.
  - Required: `res_data` = 32'h0040_0003, `res_op` = 2'b11.
  - Required: `busy` falls 1 cycle after the handshake.
- Back-pressure, DEPTH=4: hold `res_ready` = 0 and push 6 commands back-to-back.
  - Required: the 1st is popped; entries 2–5 fill the FIFO; `cmd_ready` drops; the 6th stalls.
  - Required: while `res_ready` = 0, `res_valid` and `res_data` stay constant through HOLD.
- Drain order: from the full state, release `res_ready` = 1.
  - Required: results emerge in push order, one per 4 cycles.
  - Required: the stalled 6th command is accepted the cycle after the first pop and its result is last.
- Simultaneous push/pop: FIFO holds 2 entries; the FSM pops while `cmd_valid` = 1 in the same cycle.
  - Required: occupancy stays 2; no command is lost or duplicated; pointer wrap-around is exercised past 2×DEPTH pushes.
- Reset mid-WAIT: assert `rst` for 1 cycle while in WAIT with 3 entries queued.
  - Required: at the next edge `res_valid` = 0, `cmd_ready` = 1, `busy` = 0, `fpu_a` = 0.
  - Required: no result appears afterwards; a fresh command then completes normally with LATENCY+1 latency.
